range_sequencer: RTL and testbench

Autonomous controller for the ultrasonic trigger/echo datapath. It issues trigger pulses at a programmable repetition period and times the returned echo pulse in microsecond-scale ticks. It rejects echoes that time out and averages 2^AVG_LOG2 good samples into a distance result. It sits between the raw sensor pins and the Wishbone register block, which reads dist_o and status and drives enable and start.

---
 rtl/range_pkg.sv | 19 +
 rtl/range_sequencer_echo_sync.sv | 30 +++
 rtl/range_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_range_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared encodings and sizing helpers for the ultrasonic range sequencer.
package range_pkg;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_TRIG      = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_RISE = 3'd2;
  localparam logic [ST_W-1:0] ST_MEASURE   = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLDOFF   = 3'd4;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/range_sequencer_echo_sync.sv
// Two-flop synchronizer for an asynchronous pin with registered edge pulses
// aligned to the cycle in which the synchronized level changes.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      rise_q <= meta_q & ~sync_q;
      fall_q <= ~meta_q & sync_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/range_sequencer.sv
// Trigger/echo ranging controller: fires trigger pulses on a fixed period, times
// the echo in prescaled ticks, rejects timeouts and averages good samples.
module range_sequencer
  import range_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int TICK_DIV       = 50,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int CNT_W          = 16,
  parameter int AVG_LOG2       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic                clr_err_i,
  input  logic                echo_i,
  output logic                trig_o,
  output logic [CNT_W-1:0]    dist_o,
  output logic                dist_valid_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [AVG_LOG2:0]   sample_cnt_o
);

  localparam int TRIG_W = cnt_width(TRIG_CYCLES);
  localparam int PER_W  = cnt_width(PERIOD_CYCLES);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);
  localparam int PRE_W  = cnt_width(TICK_DIV);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;

  logic echo_rise, echo_fall;

  echo_sync u_echo_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (echo_i),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  logic [ST_W-1:0]   state_q, state_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]  dist_q, dist_d;
  logic              dv_q, dv_d;
  logic              timeout_q, timeout_d;
  logic              burst_q, burst_d;

  logic              tick_en, to_hit, per_done, good, abandon;
  logic [CNT_W-1:0]  tick_inc;
  logic [ACC_W-1:0]  acc_new;
  logic [SCNT_W-1:0] scnt_new;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      trig_cnt_q <= '0;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      pre_q      <= '0;
      tick_q     <= '0;
      acc_q      <= '0;
      scnt_q     <= '0;
      dist_q     <= '0;
      dv_q       <= 1'b0;
      timeout_q  <= 1'b0;
      burst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      acc_q      <= acc_d;
      scnt_q     <= scnt_d;
      dist_q     <= dist_d;
      dv_q       <= dv_d;
      timeout_q  <= timeout_d;
      burst_q    <= burst_d;
    end
  end

  always_comb begin
    tick_en  = (pre_q == PRE_W'(TICK_DIV - 1));
    tick_inc = (tick_en && tick_q != '1) ? tick_q + 1'b1 : tick_q;
    acc_new  = acc_q + ACC_W'(tick_inc);
    scnt_new = scnt_q + 1'b1;
    to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    per_done = (per_cnt_q >= PER_W'(PERIOD_CYCLES - 1));
    good     = 1'b0;
    abandon  = 1'b0;

    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    per_cnt_d  = per_done ? per_cnt_q : per_cnt_q + 1'b1;
    to_cnt_d   = to_cnt_q;
    pre_d      = pre_q;
    tick_d     = tick_q;
    acc_d      = acc_q;
    scnt_d     = scnt_q;
    dist_d     = dist_q;
    dv_d       = 1'b0;
    timeout_d  = clr_err_i ? 1'b0 : timeout_q;
    burst_d    = burst_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i || start_i) begin
          state_d    = ST_TRIG;
          trig_cnt_d = '0;
          per_cnt_d  = '0;
          burst_d    = ~enable_i;
        end
      end
      ST_TRIG: begin
        if (trig_cnt_q == TRIG_W'(TRIG_CYCLES - 1)) begin
          state_d  = ST_WAIT_RISE;
          to_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_hit) begin
          abandon = 1'b1;
        end else if (echo_rise) begin
          state_d = ST_MEASURE;
          pre_d   = '0;
          tick_d  = '0;
        end
      end
      ST_MEASURE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        pre_d    = tick_en ? '0 : pre_q + 1'b1;
        tick_d   = tick_inc;
        // The final cycle's tick is included so the sample spans the full echo.
        if (echo_fall) good = 1'b1;
        else if (to_hit) abandon = 1'b1;
      end
      ST_HOLDOFF: begin
        if (per_done) begin
          if (enable_i || burst_q) begin
            state_d    = ST_TRIG;
            trig_cnt_d = '0;
            per_cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abandon) begin
      state_d   = ST_HOLDOFF;
      timeout_d = 1'b1;
      acc_d     = '0;
      scnt_d    = '0;
      burst_d   = 1'b0;
    end

    if (good) begin
      state_d = ST_HOLDOFF;
      if (scnt_new == SCNT_W'(1 << AVG_LOG2)) begin
        dist_d  = CNT_W'(acc_new >> AVG_LOG2);
        dv_d    = 1'b1;
        acc_d   = '0;
        scnt_d  = '0;
        burst_d = 1'b0;
      end else begin
        acc_d  = acc_new;
        scnt_d = scnt_new;
      end
    end
  end

  always_comb begin
    trig_o       = (state_q == ST_TRIG);
    busy_o       = (state_q != ST_IDLE);
    dist_o       = dist_q;
    dist_valid_o = dv_q;
    timeout_o    = timeout_q;
    sample_cnt_o = scnt_q;
  end

endmodule

// File: tb/tb_range_sequencer.sv
// Directed bench for range_sequencer: three instances cover plain, averaged
// and narrow-counter configurations with hand-computed expectations.
module tb_range_sequencer;

  logic clk;
  logic reset;

  logic en0, st0, clr0, echo0, trig0, dv0, busy0, to0;
  logic [15:0] dist0;
  logic [0:0]  sc0;

  logic en1, st1, clr1, echo1, trig1, dv1, busy1, to1;
  logic [15:0] dist1;
  logic [2:0]  sc1;

  logic en2, st2, clr2, echo2, trig2, dv2, busy2, to2;
  logic [3:0]  dist2;
  logic [0:0]  sc2;

  int errors = 0;
  int checks = 0;
  int v0 = 0, v1 = 0, v2 = 0, cyc = 0;
  int n, base;
  int rise [4];
  int w [4] = '{20, 40, 60, 80};

  range_sequencer #(.TRIG_CYCLES(4), .TICK_DIV(2), .TIMEOUT_CYCLES(200),
    .PERIOD_CYCLES(300), .CNT_W(16), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable_i(en0), .start_i(st0), .clr_err_i(clr0),
    .echo_i(echo0), .trig_o(trig0), .dist_o(dist0), .dist_valid_o(dv0),
    .busy_o(busy0), .timeout_o(to0), .sample_cnt_o(sc0));

  range_sequencer #(.TRIG_CYCLES(4), .TICK_DIV(2), .TIMEOUT_CYCLES(200),
    .PERIOD_CYCLES(300), .CNT_W(16), .AVG_LOG2(2)) u_dut1 (
    .clk(clk), .reset(reset), .enable_i(en1), .start_i(st1), .clr_err_i(clr1),
    .echo_i(echo1), .trig_o(trig1), .dist_o(dist1), .dist_valid_o(dv1),
    .busy_o(busy1), .timeout_o(to1), .sample_cnt_o(sc1));

  range_sequencer #(.TRIG_CYCLES(4), .TICK_DIV(2), .TIMEOUT_CYCLES(200),
    .PERIOD_CYCLES(300), .CNT_W(4), .AVG_LOG2(0)) u_dut2 (
    .clk(clk), .reset(reset), .enable_i(en2), .start_i(st2), .clr_err_i(clr2),
    .echo_i(echo2), .trig_o(trig2), .dist_o(dist2), .dist_valid_o(dv2),
    .busy_o(busy2), .timeout_o(to2), .sample_cnt_o(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv0) v0 <= v0 + 1;
    if (dv1) v1 <= v1 + 1;
    if (dv2) v2 <= v2 + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    {en0, st0, clr0, echo0} = '0;
    {en1, st1, clr1, echo1} = '0;
    {en2, st2, clr2, echo2} = '0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);

    chk("rst_trig", int'(trig0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_dist", int'(dist0), 0);
    chk("rst_valid", int'(dv0), 0);
    chk("rst_timeout", int'(to0), 0);
    chk("rst_scnt", int'(sc0), 0);

    // Single shot: trigger width, then a 40-cycle echo is 20 ticks
    base = v0;
    st0 = 1'b1; step(1); st0 = 1'b0;
    n = 0;
    while (trig0 && n < 50) begin n++; step(1); end
    chk("t1_trig_width", n, 4);
    echo0 = 1'b1; step(40); echo0 = 1'b0;
    n = 0;
    while (v0 == base && n < 20) begin step(1); n++; end
    chk("t1_dist", int'(dist0), 20);
    step(5);
    chk("t1_valid_pulses", v0 - base, 1);
    n = 0;
    while (busy0 && n < 400) begin step(1); n++; end
    chk("t1_busy_idle", int'(busy0), 0);
    chk("t1_dist_hold", int'(dist0), 20);
    chk("t1_no_timeout", int'(to0), 0);

    // Echo already high at trigger end must not start the measurement
    base = v0;
    echo0 = 1'b1;
    st0 = 1'b1; step(1); st0 = 1'b0;
    n = 0;
    while (trig0 && n < 50) begin n++; step(1); end
    step(3);
    echo0 = 1'b0; step(5);
    echo0 = 1'b1; step(10);
    echo0 = 1'b0;
    n = 0;
    while (v0 == base && n < 20) begin step(1); n++; end
    chk("t5_dist", int'(dist0), 5);
    n = 0;
    while (busy0 && n < 400) begin step(1); n++; end
    chk("t5_busy_idle", int'(busy0), 0);

    // No echo: timeout 200 cycles after trigger fall, sticky until cleared
    base = v0;
    st0 = 1'b1; step(1); st0 = 1'b0;
    n = 0;
    while (trig0 && n < 50) begin n++; step(1); end
    n = 0;
    while (!to0 && n < 300) begin step(1); n++; end
    chk("t3_timeout_lat", n, 200);
    step(5);
    chk("t3_sticky", int'(to0), 1);
    chk("t3_no_valid", v0 - base, 0);
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    chk("t3_clr", int'(to0), 0);
    n = 0;
    while (busy0 && n < 400) begin step(1); n++; end
    chk("t3_busy_idle", int'(busy0), 0);

    // Averaging over four samples: (10+20+30+40)/4 = 25
    en1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!trig1 && n < 400) begin step(1); n++; end
      rise[k] = cyc;
      n = 0;
      while (trig1 && n < 50) begin step(1); n++; end
      echo1 = 1'b1; step(w[k]); echo1 = 1'b0;
      step(6);
      if (k < 3) begin
        chk("t2_scnt", int'(sc1), k + 1);
        chk("t2_no_early_valid", v1, 0);
      end
    end
    chk("t2_valid_pulses", v1, 1);
    chk("t2_dist", int'(dist1), 25);
    chk("t2_scnt_clear", int'(sc1), 0);
    for (int k = 1; k < 4; k++) chk("t2_period", rise[k] - rise[k-1], 300);
    en1 = 1'b0;
    n = 0;
    while (busy1 && n < 400) begin step(1); n++; end
    chk("t2_busy_idle", int'(busy1), 0);

    // Narrow counter saturates: 100 cycles = 50 ticks, clamps to 15
    st2 = 1'b1; step(1); st2 = 1'b0;
    n = 0;
    while (trig2 && n < 50) begin n++; step(1); end
    echo2 = 1'b1; step(100); echo2 = 1'b0;
    n = 0;
    while (v2 == 0 && n < 20) begin step(1); n++; end
    chk("t4_dist_sat", int'(dist2), 15);
    chk("t4_no_timeout", int'(to2), 0);

    // Reset in the middle of a measurement
    base = v0;
    st0 = 1'b1; step(1); st0 = 1'b0;
    n = 0;
    while (trig0 && n < 50) begin n++; step(1); end
    echo0 = 1'b1; step(20);
    chk("t6_busy_pre", int'(busy0), 1);
    reset = 1'b1; step(1);
    chk("t6_trig", int'(trig0), 0);
    chk("t6_busy", int'(busy0), 0);
    chk("t6_dist", int'(dist0), 0);
    chk("t6_scnt", int'(sc0), 0);
    chk("t6_valid", int'(dv0), 0);
    echo0 = 1'b0; step(2);
    reset = 1'b0; step(10);
    chk("t6_no_valid", v0 - base, 0);
    chk("t6_stays_idle", int'(busy0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
